uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver that consumes the serial line driven by the team's `uart_tx` (top-level `rx` pin, or `tx` looped back in bench).
- Clocked from the same ring-oscillator-derived `clk` as the transmitter, with a matching `CLKS_PER_BIT` divider.
- Delivers received bytes through a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16: clocks per UART bit. Must be even and >= 4. Counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  raw serial line, asynchronous to clk, idle high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid&ready at a posedge.
- busy  output  1  receiver is mid-frame (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full and not being drained.

Behaviour:
- **Clock and reset:** one clock `clk`. Reset `rst` is asynchronous and active-high.
- **Reset values:**
  - Two-flop rx synchronizer flops = 1.
  - state = IDLE; bit counter and baud counter = 0; shift register = 0.
  - data = 0x00; valid = 0; busy = 0; frame_err = 0; overrun = 0.
- **Reset mid-frame:** the partial byte is discarded and state returns to IDLE. A held byte is also cleared.
- **Synchronizer:** all decisions use `rxs`, the output of the two-flop synchronizer. This adds 2 cycles of latency from the pin.
- **Cycle numbering:** cycle 0 is the first cycle in IDLE with rxs=0.
- **States:**
  - IDLE: on rxs=0, go to START and clear the baud counter.
  - START: at cycle CLKS_PER_BIT/2, sample rxs.
    - rxs=1: glitch; return to IDLE with no outputs.
    - rxs=0: go to DATA with baud counter reset and bit index 0.
  - DATA: sample data bit i at cycle CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT, for i = 0..7.
    - Bits are LSB first and shift into the shift register.
    - After bit 7, go to STOP.
  - STOP: sample at cycle CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
    - rxs=1: deliver the byte and go to IDLE.
    - rxs=0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then go to IDLE. This prevents a break condition from being re-received as bytes.
  - busy = 1 in every state except IDLE.
- **Delivery:** on the cycle after the good stop-bit sample, the byte reaches the holding register under these rules:
  - valid=0: data <= byte, valid <= 1.
  - valid=1 and ready=1 on the delivery cycle: the old byte is consumed, data <= new byte, valid stays 1.
  - valid=1 and ready=0: pulse overrun, keep the old data, drop the new byte.
- **Handshake:**
  - valid&ready with no delivery that cycle: valid <= 0 on the next edge.
  - data never changes while valid=1, except under the simultaneous consume-and-deliver rule above.
  - ready is ignored while valid=0.
- **Back-to-back frames:** after IDLE is re-entered at the mid-stop sample, a start edge is detected immediately. No extra idle time is required beyond half a stop bit.
- **Counter wrap:** the baud counter wraps from CLKS_PER_BIT-1 to 0. Bit index saturates at 7 within DATA.

Test Plan (CLKS_PER_BIT=16, bit period 16 clk, ready held 1 unless stated):
- **Basic byte:** drive frame 0x3F on rx.
  - valid rises exactly 2 + 153 = 155 cycles after the rx falling edge.
  - data=0x3F; valid drops the cycle after the handshake.
  - frame_err=0, overrun=0.
- **Glitch rejection:** low pulse of 5 clocks on an idle line.
  - busy high for 8 cycles, then IDLE.
  - No valid, no frame_err.
- **Framing error:** frame 0xA5 with stop bit 0 and rx held low 40 more bits, then high.
  - One frame_err pulse; valid stays 0.
  - busy stays high until rxs returns high.
  - A following 0x5A frame is received correctly.
- **Overrun:** ready=0; send 0x11 then 0x22 back-to-back.
  - data=0x11, valid=1.
  - One overrun pulse when 0x22 completes; data remains 0x11.
  - Raise ready: one handshake, then valid=0.
- **Simultaneous consume and deliver:** ready=0 after 0x11 arrives; assert ready only on 0x22's delivery cycle.
  - No overrun; data becomes 0x22 with valid continuously 1.
- **Reset mid-frame and loopback:**
  - Assert rst asynchronously during bit 4 of 0xC3: outputs go to 0 immediately and busy=0.
  - After release, connect to `uart_tx` sending 0x00, 0xFF, 0x55: all three received in order, no errors.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer, mid-bit
// sampling and a one-entry holding register behind a valid/ready handshake.
// Framing errors and overruns are reported as single-cycle pulses.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | line idle, waiting for a falling edge on the synchronized rx
// S_START    | timing to the middle of the start bit to reject glitches
// S_DATA     | sampling eight data bits, LSB first, at mid-bit
// S_STOP     | timing to the middle of the stop bit, deliver or flag error
// S_WAIT_IDLE| stop bit was low (break/framing error), wait for line high
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_sync1;
   logic          r_sync2;
   logic          w_rxs;

   logic [CW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;

   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_frame_err;
   logic          r_overrun;

   logic          w_half_tick;
   logic          w_bit_tick;
   logic          w_baud_clr;
   logic          w_bit_clr;
   logic          w_shift_en;
   logic          w_deliver;
   logic          w_frame_bad;
   logic          w_consume;

   assign w_rxs       = r_sync2;
   // The baud counter restarts at zero on entry to START and DATA, so the
   // half-bit compare lands mid start bit and every full-bit wrap after it
   // lands mid data/stop bit.
   assign w_half_tick = (r_baud == BAUD_HALF);
   assign w_bit_tick  = (r_baud == BAUD_LAST);
   assign w_consume   = r_valid & ready;

   // Two-flop synchronizer for the asynchronous rx pin, resetting to idle-high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and per-cycle datapath strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_clr  = 1'b0;
      w_bit_clr   = 1'b0;
      w_shift_en  = 1'b0;
      w_deliver   = 1'b0;
      w_frame_bad = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = S_START;
               w_baud_clr  = 1'b1;
               w_bit_clr   = 1'b1;
            end
         end
         S_START: begin
            if (w_half_tick) begin
               if (w_rxs) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_DATA;
                  w_baud_clr  = 1'b1;
                  w_bit_clr   = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (w_bit_tick) begin
               w_shift_en = 1'b1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (w_bit_tick) begin
               if (w_rxs) begin
                  w_deliver   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_frame_bad = 1'b1;
                  w_state_nxt = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (w_rxs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Baud counter: free-running wrap inside a frame, parked at zero when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud <= '0;
      end else if (w_baud_clr || r_state == S_IDLE) begin
         r_baud <= '0;
      end else if (w_bit_tick) begin
         r_baud <= '0;
      end else begin
         r_baud <= r_baud + 1'b1;
      end
   end

   // Bit index: counts data bits, holds at 7 until the FSM leaves DATA.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_idx <= '0;
      end else if (w_bit_clr) begin
         r_bit_idx <= '0;
      end else if (w_shift_en && r_bit_idx != 3'd7) begin
         r_bit_idx <= r_bit_idx + 1'b1;
      end
   end

   // Shift register: LSB arrives first, so new bits enter at the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
      end else if (w_shift_en) begin
         r_shift <= {w_rxs, r_shift[7:1]};
      end
   end

   // Holding register and handshake; a full, undrained register drops the new byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (w_deliver) begin
         if (!r_valid || ready) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end
      end else if (w_consume) begin
         r_valid <= 1'b0;
      end
   end

   // Error pulses, registered so each lasts exactly one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_frame_bad;
         r_overrun   <= w_deliver & r_valid & ~ready;
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign busy      = (r_state != S_IDLE);
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule
